// File: rtl/scumv_uart_proto_mux_pkg.sv
// Shared types and constants for the N-channel UART protocol multiplexer.
// Holds state encodings, default prefixes/bytes and a packed-field helper.
package scumv_uart_mux_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_FWD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [31:0] PREFIX_ASC   = 32'h6173_632B;  // "asc+"
    localparam logic [31:0] PREFIX_STL   = 32'h7374_6C2B;  // "stl+"
    localparam logic [7:0]  DEF_NAK_BYTE = 8'h15;
    localparam logic [7:0]  DEF_TO_BYTE  = 8'h18;
    localparam logic [7:0]  PLUS_BYTE    = 8'h2B;

    // Wide enough for 32 byte fields, covering every packed per-channel vector.
    localparam int unsigned FIELD_W = 256;

    function automatic logic [7:0] field8(input logic [FIELD_W-1:0] vec, input logic [4:0] idx);
        return vec[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/scumv_uart_proto_mux_if.sv
// Byte-stream bundle between the multiplexer, the UART FIFOs and the channel ports.
// master = the multiplexer, slave = the surrounding FIFOs and subsystems.
interface scumv_uart_proto_mux_if #(
    parameter int N_CH = 2
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        ch_req_data;
    logic [N_CH-1:0]   ch_req_valid;
    logic [N_CH-1:0]   ch_req_ready;
    logic [8*N_CH-1:0] ch_rsp_data;
    logic [N_CH-1:0]   ch_rsp_valid;
    logic [N_CH-1:0]   ch_rsp_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready, ch_req_ready, ch_rsp_data, ch_rsp_valid,
        output rx_ready, tx_data, tx_valid, ch_req_data, ch_req_valid, ch_rsp_ready
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, ch_req_ready, ch_rsp_data, ch_rsp_valid,
        input  rx_ready, tx_data, tx_valid, ch_req_data, ch_req_valid, ch_rsp_ready
    );
endinterface

// File: rtl/scumv_uart_proto_mux_prefix_matcher.sv
// Combinational 4-byte prefix comparator over the last three shifted bytes plus
// the incoming byte; the lowest-index matching channel wins.
module scumv_prefix_matcher
    import scumv_uart_mux_pkg::*;
#(
    parameter int                 N_CH     = 2,
    parameter logic [32*N_CH-1:0] PREFIXES = {PREFIX_STL, PREFIX_ASC}
) (
    input  logic [23:0] sr_i,
    input  logic [7:0]  rx_data_i,
    output logic        hit_o,
    output logic [2:0]  idx_o
);

    logic [31:0]     cand_s;
    logic [N_CH-1:0] match_s;

    // Per-channel equality against the candidate word.
    always_comb begin
        cand_s  = {sr_i, rx_data_i};
        match_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            match_s[i] = (cand_s == PREFIXES[32*i +: 32]);
        end
    end

    // Priority encode, scanning downward so the lowest index is written last.
    always_comb begin
        idx_o = 3'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx_o = match_s[i] ? 3'(i) : idx_o;
        end
        hit_o = |match_s;
    end

endmodule

// File: rtl/scumv_uart_proto_mux.sv
// N-channel UART protocol multiplexer: hunts for a channel prefix, forwards the
// request bytes, returns the response bytes, and reports NAK/timeout errors.
module scumv_uart_proto_mux
    import scumv_uart_mux_pkg::*;
#(
    parameter int                 N_CH           = 2,
    parameter logic [32*N_CH-1:0] PREFIXES       = {PREFIX_STL, PREFIX_ASC},
    parameter logic [8*N_CH-1:0]  REQ_LEN        = {8'd16, 8'd22},
    parameter logic [8*N_CH-1:0]  RSP_LEN        = {8'd16, 8'd1},
    parameter int                 TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]         NAK_BYTE       = DEF_NAK_BYTE,
    parameter logic [7:0]         TO_BYTE        = DEF_TO_BYTE
) (
    input  logic                  clk,
    input  logic                  reset,
    scumv_uart_proto_mux_if.master bus,
    output logic [2:0]            active_ch,
    output logic                  busy,
    output logic [7:0]            err_count,
    output logic [1:0]            dbg_state
);

    localparam int                TMR_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FIELD_W-1:0] REQ_LEN_W = FIELD_W'(REQ_LEN);
    localparam logic [FIELD_W-1:0] RSP_LEN_W = FIELD_W'(RSP_LEN);

    state_e            state_q, state_d;
    logic [23:0]       sr_q, sr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        err_q, err_d;
    logic [7:0]        err_byte_q, err_byte_d;

    logic              hit_s;
    logic [2:0]        idx_s;
    logic              enter_err_s;
    logic [N_CH-1:0]   sel_oh_s;
    logic [7:0]        req_len_s;
    logic [7:0]        rsp_len_s;
    logic [7:0]        rsp_data_s;
    logic              req_rdy_sel_s;
    logic              rsp_vld_sel_s;

    logic              rx_ready_s;
    logic              tx_valid_s;
    logic [7:0]        tx_data_s;
    logic [N_CH-1:0]   req_valid_s;
    logic [N_CH-1:0]   rsp_ready_s;

    scumv_prefix_matcher #(
        .N_CH     (N_CH),
        .PREFIXES (PREFIXES)
    ) u_matcher (
        .sr_i      (sr_q),
        .rx_data_i (bus.rx_data),
        .hit_o     (hit_s),
        .idx_o     (idx_s)
    );

    // Per-channel selections for the currently latched channel.
    always_comb begin
        sel_oh_s      = N_CH'(1'b1) << sel_q;
        req_len_s     = field8(REQ_LEN_W, {2'b00, sel_q});
        rsp_len_s     = field8(RSP_LEN_W, {2'b00, sel_q});
        rsp_data_s    = field8(FIELD_W'(bus.ch_rsp_data), {2'b00, sel_q});
        req_rdy_sel_s = |(bus.ch_req_ready & sel_oh_s);
        rsp_vld_sel_s = |(bus.ch_rsp_valid & sel_oh_s);
    end

    // Next-state logic and ungated datapath steering.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        sel_d       = sel_q;
        err_byte_d  = err_byte_q;
        enter_err_s = 1'b0;
        rx_ready_s  = 1'b0;
        tx_valid_s  = 1'b0;
        tx_data_s   = 8'h00;
        req_valid_s = '0;
        rsp_ready_s = '0;

        case (state_q)
            ST_HUNT: begin
                rx_ready_s = 1'b1;
                if (bus.rx_valid) begin
                    sr_d = {sr_q[15:0], bus.rx_data};
                    if (hit_s) begin
                        state_d = ST_FWD;
                        sel_d   = idx_s;
                        cnt_d   = 8'd0;
                        tmr_d   = '0;
                        sr_d    = 24'd0;
                    end else if (bus.rx_data == PLUS_BYTE) begin
                        state_d     = ST_ERR;
                        err_byte_d  = NAK_BYTE;
                        enter_err_s = 1'b1;
                        sr_d        = 24'd0;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end else begin
                    sr_d = sr_q;
                end
            end

            ST_FWD: begin
                req_valid_s = sel_oh_s & {N_CH{bus.rx_valid}};
                rx_ready_s  = req_rdy_sel_s;
                if (bus.rx_valid && req_rdy_sel_s) begin
                    tmr_d = '0;
                    if (cnt_q == req_len_s - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = (rsp_len_s == 8'd0) ? ST_HUNT : ST_RSP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (!bus.rx_valid) begin
                    // Only a silent source ages the packet; back-pressure does not.
                    if (tmr_q == TMR_MAX) begin
                        state_d     = ST_ERR;
                        err_byte_d  = TO_BYTE;
                        enter_err_s = 1'b1;
                        tmr_d       = '0;
                        cnt_d       = 8'd0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1'b1);
                    end
                end else begin
                    tmr_d = tmr_q;
                end
            end

            ST_RSP: begin
                tx_valid_s  = rsp_vld_sel_s;
                tx_data_s   = rsp_data_s;
                rsp_ready_s = sel_oh_s & {N_CH{bus.tx_ready}};
                if (rsp_vld_sel_s && bus.tx_ready) begin
                    tmr_d = '0;
                    if (cnt_q == rsp_len_s - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = ST_HUNT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (!rsp_vld_sel_s) begin
                    if (tmr_q == TMR_MAX) begin
                        state_d     = ST_ERR;
                        err_byte_d  = TO_BYTE;
                        enter_err_s = 1'b1;
                        tmr_d       = '0;
                        cnt_d       = 8'd0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1'b1);
                    end
                end else begin
                    tmr_d = tmr_q;
                end
            end

            ST_ERR: begin
                tx_valid_s = 1'b1;
                tx_data_s  = err_byte_q;
                if (bus.tx_ready) begin
                    state_d = ST_HUNT;
                    sr_d    = 24'd0;
                end else begin
                    state_d = ST_ERR;
                end
            end

            default: begin
                state_d = ST_HUNT;
                sr_d    = 24'd0;
            end
        endcase

        err_d = (enter_err_s && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            sr_q       <= 24'd0;
            cnt_q      <= 8'd0;
            tmr_q      <= '0;
            sel_q      <= 3'd0;
            err_q      <= 8'd0;
            err_byte_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            err_byte_q <= err_byte_d;
        end
    end

    // Handshake outputs are forced quiet while reset is held, even mid-packet.
    always_comb begin
        bus.ch_req_data = bus.rx_data;
        err_count       = err_q;
        dbg_state       = state_q;
        if (reset) begin
            bus.rx_ready     = 1'b0;
            bus.tx_valid     = 1'b0;
            bus.tx_data      = 8'h00;
            bus.ch_req_valid = '0;
            bus.ch_rsp_ready = '0;
            busy             = 1'b0;
            active_ch        = 3'd0;
        end else begin
            bus.rx_ready     = rx_ready_s;
            bus.tx_valid     = tx_valid_s;
            bus.tx_data      = tx_data_s;
            bus.ch_req_valid = req_valid_s;
            bus.ch_rsp_ready = rsp_ready_s;
            busy             = (state_q != ST_HUNT);
            active_ch        = (state_q != ST_HUNT) ? sel_q : 3'd0;
        end
    end

endmodule
